// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and sizing for the sequential Booth multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_STEPS = 32;

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one radix-2 Booth iteration: add/sub M, then arithmetic shift {A,Q,Q_1}
module booth_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_a,
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_q_1,
  input  logic [WIDTH:0]   i_m,
  output logic [WIDTH:0]   o_a,
  output logic [WIDTH-1:0] o_q,
  output logic             o_q_1
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    w_sum = i_a;
    case ({i_q[0], i_q_1})
      2'b01:   w_sum = i_a + i_m;
      2'b10:   w_sum = i_a - i_m;
      default: w_sum = i_a;
    endcase
  end

  // The 33-bit A keeps its sign bit, so replicating it is a true arithmetic shift.
  assign o_a   = {w_sum[WIDTH], w_sum[WIDTH:1]};
  assign o_q   = {w_sum[0], i_q[WIDTH-1:1]};
  assign o_q_1 = i_q[0];

endmodule

// File: rtl/booth_mult.sv
// rtl/booth_mult.sv - sequential signed multiplier, one Booth step per clock, product on hi/low
module booth_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int STEPS = MULT_STEPS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             multInit,
  input  logic [WIDTH-1:0] value_A,
  input  logic [WIDTH-1:0] value_B,
  output logic             multBusy,
  output logic             multDone,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] low
);

  localparam int CNT_W = $clog2(STEPS) + 1;

  state_t           r_state;
  logic [WIDTH:0]   r_a;
  logic [WIDTH:0]   r_m;
  logic [WIDTH-1:0] r_q;
  logic             r_q_1;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH:0]   w_a_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_q_1_nxt;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .i_a   (r_a),
    .i_q   (r_q),
    .i_q_1 (r_q_1),
    .i_m   (r_m),
    .o_a   (w_a_nxt),
    .o_q   (w_q_nxt),
    .o_q_1 (w_q_1_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_m      <= '0;
      r_q      <= '0;
      r_q_1    <= 1'b0;
      r_cnt    <= '0;
      multBusy <= 1'b0;
      multDone <= 1'b0;
      hi       <= '0;
      low      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          multDone <= 1'b0;
          if (multInit) begin
            r_m      <= {value_A[WIDTH-1], value_A};
            r_a      <= '0;
            r_q      <= value_B;
            r_q_1    <= 1'b0;
            r_cnt    <= '0;
            multBusy <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_q_1 <= w_q_1_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(STEPS - 1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          // Bit WIDTH of A is only sign guard; the product is {A[WIDTH-1:0], Q}.
          hi       <= r_a[WIDTH-1:0];
          low      <= r_q;
          multDone <= 1'b1;
          multBusy <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult.sv
// tb/tb_booth_mult.sv - directed and random self-checking bench for booth_mult
module tb_booth_mult;

  logic        clk = 1'b0;
  logic        reset;
  logic        multInit;
  logic [31:0] value_A;
  logic [31:0] value_B;
  logic        multBusy;
  logic        multDone;
  logic [31:0] hi;
  logic [31:0] low;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_mult dut (
    .clk      (clk),
    .reset    (reset),
    .multInit (multInit),
    .value_A  (value_A),
    .value_B  (value_B),
    .multBusy (multBusy),
    .multDone (multDone),
    .hi       (hi),
    .low      (low)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start a multiply, optionally poke a second start at RUN cycle poke_at, and
  // check the latency, busy behaviour, done pulse width and product.
  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int poke_at,
                          input bit full, input string tag);
    int  k;
    bit  seen;
    bit  busy_ok;
    multInit = 1'b1;
    value_A  = a;
    value_B  = b;
    step();
    multInit = 1'b0;
    value_A  = 32'hDEAD_BEEF;
    value_B  = 32'h1234_5678;
    k       = 0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    while (!seen && k < 40) begin
      if (k == poke_at) begin
        multInit = 1'b1;
        value_A  = 32'd9;
        value_B  = 32'd9;
      end
      step();
      k++;
      multInit = 1'b0;
      if (multDone) seen = 1'b1;
      else if (!multBusy) busy_ok = 1'b0;
    end
    if (full) begin
      check({tag, "_latency"}, 64'(k), 64'd33);
      check({tag, "_busy"}, {63'd0, busy_ok}, 64'd1);
      check({tag, "_busy_at_done"}, {63'd0, multBusy}, 64'd0);
    end
    check({tag, "_product"}, {hi, low}, exp);
    step();
    if (full) check({tag, "_done_pulse"}, {63'd0, multDone}, 64'd0);
  endtask

  initial begin
    int          k;
    int          first_done;
    int          second_done;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] rexp;

    reset    = 1'b1;
    multInit = 1'b1;
    value_A  = 32'd5;
    value_B  = 32'd5;
    step();
    step();
    check("reset_busy", {63'd0, multBusy}, 64'd0);
    check("reset_done", {63'd0, multDone}, 64'd0);
    check("reset_hilo", {hi, low}, 64'd0);
    multInit = 1'b0;
    reset    = 1'b0;
    step();

    run_mult(32'd3, 32'd4, 64'h0000_0000_0000_000C, -1, 1'b1, "t1_3x4");
    run_mult(32'hFFFF_FFF9, 32'd5, 64'hFFFF_FFFF_FFFF_FFDD, -1, 1'b1, "t2_m7x5");
    run_mult(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1, 1'b1, "t3_min_sq");
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, -1, 1'b1, "t4_m1sq");
    run_mult(32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, -1, 1'b1, "t4_max_min");

    run_mult(32'd6, 32'd7, 64'd42, 10, 1'b1, "t5_ignore");
    check("t5_idle_busy", {63'd0, multBusy}, 64'd0);
    for (int i = 0; i < 5; i++) step();
    check("t5_hold", {hi, low}, 64'd42);
    check("t5_no_done", {63'd0, multDone}, 64'd0);

    multInit = 1'b1;
    value_A  = 32'd6;
    value_B  = 32'd7;
    step();
    multInit = 1'b0;
    for (int i = 0; i < 15; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_busy", {63'd0, multBusy}, 64'd0);
    check("t6_done", {63'd0, multDone}, 64'd0);
    check("t6_hilo", {hi, low}, 64'd0);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (multDone || multBusy) k++;
    end
    check("t6_no_done_after_reset", 64'(k), 64'd0);
    run_mult(32'd2, 32'd3, 64'd6, -1, 1'b1, "t6_2x3");

    multInit    = 1'b1;
    value_A     = 32'd3;
    value_B     = 32'd4;
    first_done  = 0;
    second_done = 0;
    for (int e = 1; e <= 80 && second_done == 0; e++) begin
      step();
      if (multDone) begin
        if (first_done == 0) first_done = e;
        else begin
          second_done = e;
          multInit    = 1'b0;
        end
      end
    end
    multInit = 1'b0;
    check("held_first_done", 64'(first_done), 64'd34);
    check("held_period", 64'(second_done - first_done), 64'd34);
    check("held_product", {hi, low}, 64'd12);
    step();
    step();
    check("held_stops", {62'd0, multBusy, multDone}, 64'd0);

    for (int i = 0; i < 1000; i++) begin
      ra   = $urandom;
      rb   = $urandom;
      rexp = $signed({{32{ra[31]}}, ra}) * $signed({{32{rb[31]}}, rb});
      run_mult(ra, rb, rexp, -1, 1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
